ov7670_cam_init: RTL and testbench

OV7670 power-up configuration block: walks a 77-entry register ROM and writes each {register address, data} pair to the camera over an SCCB (I2C-like) open-drain bus. It contains the ROM, the sequencing FSM and a byte-level SCCB write master. It sits between the top-level start/reset logic and the camera's SIOC/SIOD pins, and must finish before the capture path is enabled.

---
 rtl/ov7670_cam_init.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_ov7670_cam_init.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ov7670_cam_init.sv
// OV7670 power-up configuration: walks the init ROM and writes each
// {reg_addr, reg_data} pair to the camera over an open-drain SCCB bus.
//
//   state     | meaning
//   ----------+------------------------------------------------------
//   ST_IDLE   | bus released, waiting for start
//   ST_FETCH  | ROM pointer applied, waiting one clock of ROM latency
//   ST_DECODE | ROM word valid: end marker, delay marker or write
//   ST_WRITE  | SCCB engine running a 3-phase write
//   ST_DELAY  | silent wait of DELAY_CYC clocks
//   ST_DONE   | sequence complete, sticky until reset
module ov7670_cam_init #(
    parameter int CLK_F     = 100_000_000,
    parameter int SCCB_F    = 400_000,
    parameter int DELAY_CYC = 1_000_000
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_cam_init_start,
    output logic            o_cam_init_done,
    output wire logic       o_sioc,
    output wire logic       o_siod,
    output logic            o_data_sent_done,
    output wire logic [7:0] o_SCCB_dout
);

    localparam int P  = CLK_F / SCCB_F;
    localparam int H  = P / 2;
    localparam int Q  = P / 4;
    localparam int TW = $clog2(P);
    localparam int DW = (DELAY_CYC > 1) ? $clog2(DELAY_CYC) : 1;

    localparam logic [TW-1:0] T_BIT       = TW'(P - 1);
    localparam logic [TW-1:0] T_HALF      = TW'(H - 1);
    localparam logic [TW-1:0] T_QTR       = TW'(Q - 1);
    localparam logic [TW-1:0] T_SIOC_UP   = TW'(P - H);
    localparam logic [TW-1:0] T_SIOD_BIT  = TW'(P - Q);
    localparam logic [TW-1:0] T_SIOD_STOP = TW'(H - Q);
    localparam logic [DW-1:0] D_LOAD      = DW'(DELAY_CYC - 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_FETCH, ST_DECODE, ST_WRITE, ST_DELAY, ST_DONE
    } state_t;

    typedef enum logic [2:0] {
        B_IDLE, B_START_A, B_START_B, B_BIT, B_STOP_A, B_STOP_B, B_STOP_C
    } bus_t;

    function automatic logic [15:0] rom_word(input logic [6:0] a);
        logic [15:0] w;
        case (a)
            7'd0:  w = 16'h1280; 7'd1:  w = 16'hFFF0; 7'd2:  w = 16'h1204; 7'd3:  w = 16'h1100;
            7'd4:  w = 16'h0C00; 7'd5:  w = 16'h3E00; 7'd6:  w = 16'h8C00; 7'd7:  w = 16'h0400;
            7'd8:  w = 16'h40D0; 7'd9:  w = 16'h3A04; 7'd10: w = 16'h1418; 7'd11: w = 16'h4FB3;
            7'd12: w = 16'h50B3; 7'd13: w = 16'h5100; 7'd14: w = 16'h523D; 7'd15: w = 16'h53A7;
            7'd16: w = 16'h54E4; 7'd17: w = 16'h589E; 7'd18: w = 16'h3DC0; 7'd19: w = 16'h1714;
            7'd20: w = 16'h1802; 7'd21: w = 16'h3280; 7'd22: w = 16'h1903; 7'd23: w = 16'h1A7B;
            7'd24: w = 16'h030A; 7'd25: w = 16'h0F41; 7'd26: w = 16'h1E00; 7'd27: w = 16'h330B;
            7'd28: w = 16'h3C78; 7'd29: w = 16'h6900; 7'd30: w = 16'h7400; 7'd31: w = 16'hB084;
            7'd32: w = 16'hB10C; 7'd33: w = 16'hB20E; 7'd34: w = 16'hB380; 7'd35: w = 16'h703A;
            7'd36: w = 16'h7135; 7'd37: w = 16'h7211; 7'd38: w = 16'h73F0; 7'd39: w = 16'hA202;
            7'd40: w = 16'h7A20; 7'd41: w = 16'h7B10; 7'd42: w = 16'h7C1E; 7'd43: w = 16'h7D35;
            7'd44: w = 16'h7E5A; 7'd45: w = 16'h7F69; 7'd46: w = 16'h8076; 7'd47: w = 16'h8180;
            7'd48: w = 16'h8288; 7'd49: w = 16'h838F; 7'd50: w = 16'h8496; 7'd51: w = 16'h85A3;
            7'd52: w = 16'h86AF; 7'd53: w = 16'h87C4; 7'd54: w = 16'h88D7; 7'd55: w = 16'h89E8;
            7'd56: w = 16'h13E0; 7'd57: w = 16'h0000; 7'd58: w = 16'h1000; 7'd59: w = 16'h0D40;
            7'd60: w = 16'hA505; 7'd61: w = 16'hAB07; 7'd62: w = 16'h2495; 7'd63: w = 16'h2533;
            7'd64: w = 16'h26E3; 7'd65: w = 16'h9F78; 7'd66: w = 16'hA068; 7'd67: w = 16'hA103;
            7'd68: w = 16'hA6D8; 7'd69: w = 16'hA7D8; 7'd70: w = 16'hA8F0; 7'd71: w = 16'hA990;
            7'd72: w = 16'hAA94; 7'd73: w = 16'h13E5; 7'd74: w = 16'h0E61; 7'd75: w = 16'h1602;
            default: w = 16'hFFFF;
        endcase
        return w;
    endfunction

    state_t        state, state_d;
    logic [6:0]    ptr, ptr_d;
    logic [DW-1:0] dly, dly_d;
    logic [15:0]   rom_q;
    logic          wr_go, wr_done;

    bus_t          bstate, bstate_d;
    logic [TW-1:0] tmr, tmr_d;
    logic [1:0]    phase, phase_d;
    logic [3:0]    bitn, bitn_d;
    logic          sioc_low, sioc_low_d, siod_low, siod_low_d;
    logic [7:0]    dout_q, dout_d;
    logic          sent_q, sent_d;
    logic [7:0]    cur_byte;
    logic          bit_val;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= ST_IDLE;
            ptr   <= '0;
            dly   <= '0;
            rom_q <= '0;
        end else begin
            state <= state_d;
            ptr   <= ptr_d;
            dly   <= dly_d;
            rom_q <= rom_word(ptr);
        end
    end

    always_comb begin
        state_d = state;
        ptr_d   = ptr;
        dly_d   = dly;
        wr_go   = 1'b0;
        case (state)
            ST_IDLE:   if (i_cam_init_start) state_d = ST_FETCH;
            ST_FETCH:  state_d = ST_DECODE;
            ST_DECODE: begin
                if (rom_q == 16'hFFFF) begin
                    state_d = ST_DONE;
                end else if (rom_q == 16'hFFF0) begin
                    state_d = ST_DELAY;
                    dly_d   = D_LOAD;
                end else begin
                    state_d = ST_WRITE;
                    wr_go   = 1'b1;
                end
            end
            ST_WRITE: begin
                if (wr_done) begin
                    state_d = ST_FETCH;
                    ptr_d   = ptr + 7'd1;
                end
            end
            ST_DELAY: begin
                if (dly == '0) begin
                    state_d = ST_FETCH;
                    ptr_d   = ptr + 7'd1;
                end else begin
                    dly_d = dly - DW'(1);
                end
            end
            ST_DONE:  state_d = ST_DONE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        case (phase)
            2'd0:    cur_byte = 8'h42;
            2'd1:    cur_byte = rom_q[15:8];
            default: cur_byte = rom_q[7:0];
        endcase
    end

    // 9th bit of each phase is the ACK slot: SIOD stays released
    assign bit_val = (bitn == 4'd8) ? 1'b1 : cur_byte[~bitn[2:0]];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            bstate   <= B_IDLE;
            tmr      <= '0;
            phase    <= '0;
            bitn     <= '0;
            sioc_low <= 1'b0;
            siod_low <= 1'b0;
            dout_q   <= 8'hFF;
            sent_q   <= 1'b0;
        end else begin
            bstate   <= bstate_d;
            tmr      <= tmr_d;
            phase    <= phase_d;
            bitn     <= bitn_d;
            sioc_low <= sioc_low_d;
            siod_low <= siod_low_d;
            dout_q   <= dout_d;
            sent_q   <= sent_d;
        end
    end

    always_comb begin
        bstate_d   = bstate;
        tmr_d      = tmr;
        phase_d    = phase;
        bitn_d     = bitn;
        sioc_low_d = sioc_low;
        siod_low_d = siod_low;
        dout_d     = dout_q;
        sent_d     = 1'b0;
        wr_done    = 1'b0;
        case (bstate)
            B_IDLE: begin
                sioc_low_d = 1'b0;
                siod_low_d = 1'b0;
                if (wr_go) begin
                    bstate_d = B_START_A;
                    tmr_d    = T_QTR;
                end
            end
            B_START_A: begin
                if (tmr == '0) begin
                    siod_low_d = 1'b1;
                    bstate_d   = B_START_B;
                    tmr_d      = T_QTR;
                end else begin
                    tmr_d = tmr - TW'(1);
                end
            end
            B_START_B: begin
                if (tmr == '0) begin
                    sioc_low_d = 1'b1;
                    bstate_d   = B_BIT;
                    tmr_d      = T_BIT;
                    phase_d    = 2'd0;
                    bitn_d     = 4'd0;
                end else begin
                    tmr_d = tmr - TW'(1);
                end
            end
            B_BIT: begin
                // SIOD moves a quarter period into the low half, SIOC rises at mid-bit
                if (tmr == T_SIOD_BIT) siod_low_d = ~bit_val;
                if (tmr == T_SIOC_UP)  sioc_low_d = 1'b0;
                if (tmr == '0) begin
                    sioc_low_d = 1'b1;
                    tmr_d      = T_BIT;
                    if (bitn == 4'd8) begin
                        sent_d = 1'b1;
                        dout_d = cur_byte;
                        bitn_d = 4'd0;
                        if (phase == 2'd2) begin
                            bstate_d = B_STOP_A;
                            tmr_d    = T_HALF;
                        end else begin
                            phase_d = phase + 2'd1;
                        end
                    end else begin
                        bitn_d = bitn + 4'd1;
                    end
                end else begin
                    tmr_d = tmr - TW'(1);
                end
            end
            B_STOP_A: begin
                if (tmr == T_SIOD_STOP) siod_low_d = 1'b1;
                if (tmr == '0) begin
                    sioc_low_d = 1'b0;
                    bstate_d   = B_STOP_B;
                    tmr_d      = T_QTR;
                end else begin
                    tmr_d = tmr - TW'(1);
                end
            end
            B_STOP_B: begin
                if (tmr == '0) begin
                    siod_low_d = 1'b0;
                    bstate_d   = B_STOP_C;
                    tmr_d      = T_QTR;
                end else begin
                    tmr_d = tmr - TW'(1);
                end
            end
            B_STOP_C: begin
                if (tmr == '0) begin
                    bstate_d = B_IDLE;
                    wr_done  = 1'b1;
                end else begin
                    tmr_d = tmr - TW'(1);
                end
            end
            default: bstate_d = B_IDLE;
        endcase
    end

    assign o_sioc           = sioc_low ? 1'b0 : 1'bz;
    assign o_siod           = siod_low ? 1'b0 : 1'bz;
    assign o_cam_init_done  = (state == ST_DONE);
    assign o_data_sent_done = sent_q;

    for (genvar i = 0; i < 8; i++) begin : g_dout
        assign o_SCCB_dout[i] = dout_q[i] ? 1'bz : 1'b0;
    end

endmodule

// File: tb/tb_ov7670_cam_init.sv
// Bench for ov7670_cam_init: expected write triples table plus a wire-level
// SCCB decoder, with reset, delay, completion and mid-write reset sequences.
module tb_ov7670_cam_init;

    localparam int CLK_F     = 800;
    localparam int SCCB_F    = 100;
    localparam int DELAY_CYC = 300;
    localparam int P         = CLK_F / SCCB_F;

    localparam logic [15:0] WORDS [77] = '{
        16'h1280, 16'hFFF0, 16'h1204, 16'h1100, 16'h0C00, 16'h3E00, 16'h8C00, 16'h0400,
        16'h40D0, 16'h3A04, 16'h1418, 16'h4FB3, 16'h50B3, 16'h5100, 16'h523D, 16'h53A7,
        16'h54E4, 16'h589E, 16'h3DC0, 16'h1714, 16'h1802, 16'h3280, 16'h1903, 16'h1A7B,
        16'h030A, 16'h0F41, 16'h1E00, 16'h330B, 16'h3C78, 16'h6900, 16'h7400, 16'hB084,
        16'hB10C, 16'hB20E, 16'hB380, 16'h703A, 16'h7135, 16'h7211, 16'h73F0, 16'hA202,
        16'h7A20, 16'h7B10, 16'h7C1E, 16'h7D35, 16'h7E5A, 16'h7F69, 16'h8076, 16'h8180,
        16'h8288, 16'h838F, 16'h8496, 16'h85A3, 16'h86AF, 16'h87C4, 16'h88D7, 16'h89E8,
        16'h13E0, 16'h0000, 16'h1000, 16'h0D40, 16'hA505, 16'hAB07, 16'h2495, 16'h2533,
        16'h26E3, 16'h9F78, 16'hA068, 16'hA103, 16'hA6D8, 16'hA7D8, 16'hA8F0, 16'hA990,
        16'hAA94, 16'h13E5, 16'h0E61, 16'h1602, 16'hFFFF
    };

    typedef struct {
        int         widx;
        logic       start_lvl;
        logic [7:0] id;
        logic [7:0] addr;
        logic [7:0] data;
    } vec_t;

    vec_t vecs [75];

    logic clk = 1'b0;
    logic rst, start;
    logic done, sent;
    tri1       sioc, siod;
    tri1 [7:0] dout;

    ov7670_cam_init #(.CLK_F(CLK_F), .SCCB_F(SCCB_F), .DELAY_CYC(DELAY_CYC)) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_cam_init_start (start),
        .o_cam_init_done  (done),
        .o_sioc           (sioc),
        .o_siod           (siod),
        .o_data_sent_done (sent),
        .o_SCCB_dout      (dout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Wire-level SCCB observer: start/stop counts and bytes decoded on SIOC rises
    logic       p_sioc = 1'b1, p_siod = 1'b1;
    logic [8:0] sh = '0;
    int         bitc = 0, n_start = 0, n_stop = 0, wr_n = 0;
    logic [7:0] wire_b [1024];

    always @(negedge clk) begin
        logic c, d;
        c = (sioc !== 1'b0);
        d = (siod !== 1'b0);
        if (rst === 1'b1) begin
            bitc = 0;
        end else if (c && p_sioc && p_siod && !d) begin
            n_start = n_start + 1;
            bitc = 0;
        end else if (c && p_sioc && !p_siod && d) begin
            n_stop = n_stop + 1;
        end else if (c && !p_sioc) begin
            sh = {sh[7:0], d};
            bitc = bitc + 1;
            if (bitc == 9) begin
                if (wr_n < 1024) wire_b[wr_n] = sh[8:1];
                wr_n = wr_n + 1;
                bitc = 0;
            end
        end
        p_sioc = c;
        p_siod = d;
    end

    int n_err = 0, n_chk = 0;
    int rd_n = 0, n_pulse = 0, early_done = 0, t_last = 0, gap = 0;

    function automatic logic [7:0] rel_byte(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = (v[i] !== 1'b0);
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_sioc"}, 32'(sioc !== 1'b0), 1);
        check({tag, "_siod"}, 32'(siod !== 1'b0), 1);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_sent"}, 32'(sent), 0);
        check({tag, "_dout"}, 32'(rel_byte(dout)), 32'hFF);
    endtask

    task automatic expect_pulse(input string tag, input logic [7:0] exp_b);
        logic [7:0] b;
        bit ok;
        ok = 0;
        b  = '0;
        for (int i = 0; i < 800 && !ok; i++) begin
            @(negedge clk);
            if (done === 1'b1) early_done++;
            if (sent === 1'b1) begin
                ok = 1;
                b  = rel_byte(dout);
            end
        end
        if (!ok) begin
            n_chk++;
            n_err++;
            $display("FAIL %s_timeout: no sent pulse within 800 clocks, expected byte %0h", tag, exp_b);
            $display("Result: errors=%0d of %0d checks", n_err, n_chk);
            $finish;
        end else begin
            n_pulse++;
            check({tag, "_dout"}, 32'(b), 32'(exp_b));
            if (rd_n < wr_n) begin
                check({tag, "_wire"}, 32'(wire_b[rd_n % 1024]), 32'(exp_b));
                rd_n++;
            end else begin
                check({tag, "_wire_count"}, wr_n, rd_n + 1);
            end
            gap    = cyc - t_last;
            t_last = cyc;
        end
    endtask

    task automatic expect_write(input int r);
        start = vecs[r].start_lvl;
        expect_pulse($sformatf("w%0d_id", vecs[r].widx), vecs[r].id);
        if (r == 1)
            check("delay_gap", 32'(gap > DELAY_CYC && gap < DELAY_CYC + 200), 1);
        expect_pulse($sformatf("w%0d_addr", vecs[r].widx), vecs[r].addr);
        check($sformatf("w%0d_addr_spacing", vecs[r].widx), gap, 9 * P);
        expect_pulse($sformatf("w%0d_data", vecs[r].widx), vecs[r].data);
        check($sformatf("w%0d_data_spacing", vecs[r].widx), gap, 9 * P);
    endtask

    initial begin
        logic [15:0] wd;
        int          n, quiet;
        bit          ok;

        n = 0;
        for (int w = 0; w < 77; w++) begin
            wd = WORDS[w];
            if (wd != 16'hFFFF && wd != 16'hFFF0 && n < 75) begin
                vecs[n].widx      = w;
                vecs[n].start_lvl = (n % 4 != 1);
                vecs[n].id        = 8'h42;
                vecs[n].addr      = wd[15:8];
                vecs[n].data      = wd[7:0];
                n++;
            end
        end

        rst   = 1'b1;
        start = 1'b0;
        repeat (4) @(negedge clk);
        check_reset("reset");
        rst = 1'b0;

        quiet = 0;
        repeat (60) begin
            @(negedge clk);
            if (sioc === 1'b0 || siod === 1'b0 || sent === 1'b1 || done === 1'b1) quiet++;
        end
        check("idle_quiet", quiet, 0);

        t_last = cyc;
        for (int r = 0; r < 75; r++) expect_write(r);

        ok = 0;
        quiet = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (done === 1'b1) ok = 1;
            if (sent === 1'b1) quiet++;
        end
        check("done_rise", 32'(ok), 1);
        check("extra_pulses", quiet, 0);
        check("pulse_total", n_pulse, 225);
        check("early_done", early_done, 0);
        check("start_conditions", n_start, 75);
        check("stop_conditions", n_stop, 75);

        quiet = 0;
        for (int i = 0; i < 300; i++) begin
            start = i[3];
            @(negedge clk);
            if (done !== 1'b1 || sent === 1'b1 || sioc === 1'b0 || siod === 1'b0) quiet++;
        end
        check("done_sticky", quiet, 0);

        rst = 1'b1;
        @(negedge clk);
        check_reset("rst_after_done");
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        rd_n   = wr_n;
        t_last = cyc;
        for (int r = 0; r < 9; r++) expect_write(r);
        start = 1'b1;
        expect_pulse("w10_id_2nd", vecs[9].id);
        expect_pulse("w10_addr_2nd", vecs[9].addr);
        repeat (30) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset("rst_mid_data");
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        quiet = 0;
        repeat (40) begin
            @(negedge clk);
            if (sioc === 1'b0 || siod === 1'b0 || sent === 1'b1 || done === 1'b1) quiet++;
        end
        check("idle_after_abort", quiet, 0);

        rd_n   = wr_n;
        t_last = cyc;
        expect_write(0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
